// File: rtl/divisor_secuencial_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divisor_pkg;
    localparam int DIV_N = 32;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        CALCULO = 2'd1,
        FIN     = 2'd2
    } estado_div_t;
endpackage

// File: rtl/divisor_secuencial_paso_restador.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference only when it does not go negative.
module paso_restador #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem,
    input  logic [N-1:0] divisor,
    input  logic         bit_in,
    output logic [N-1:0] rem_nuevo,
    output logic         bit_q
);
    logic [N:0]   desp;
    logic [N+1:0] dif;
    logic         unused_dif;

    // One guard bit above the shifted remainder so the borrow is visible.
    assign desp       = {rem, bit_in};
    assign dif        = {1'b0, desp} - {2'b00, divisor};
    assign bit_q      = ~dif[N+1];
    assign rem_nuevo  = bit_q ? dif[N-1:0] : desp[N-1:0];
    assign unused_dif = dif[N];
endmodule

// File: rtl/divisor_secuencial.sv
// Multi-cycle restoring divider, one quotient bit per cycle, fixed N+1 latency.
// Signed operation is compiled in only when DIV_SIGNED_EN is defined.
module divisor_secuencial
    import divisor_pkg::*;
#(
    parameter int N  = DIV_N,
    parameter int CW = $clog2(N+1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inicio,
    input  logic         con_signo,
    input  logic [N-1:0] dividendo,
    input  logic [N-1:0] divisor,
    output logic         ocupado,
    output logic         valido,
    output logic [N-1:0] cociente,
    output logic [N-1:0] residuo,
    output logic         div_cero
);
    estado_div_t   estado, estado_sig;
    logic [N-1:0]  rem, quo, dsr, rem_paso, quo_paso;
    logic [N-1:0]  dvd_mag, dsr_mag, coc_fin, res_fin;
    logic [CW-1:0] cnt;
    logic          q_bit, ultimo;

    paso_restador #(.N(N)) u_paso (
        .rem       (rem),
        .divisor   (dsr),
        .bit_in    (quo[N-1]),
        .rem_nuevo (rem_paso),
        .bit_q     (q_bit)
    );

    assign quo_paso = {quo[N-2:0], q_bit};
    assign ultimo   = (cnt == CW'(1));

`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r;

    assign dvd_mag = (con_signo && dividendo[N-1]) ? -dividendo : dividendo;
    assign dsr_mag = (con_signo && divisor[N-1])   ? -divisor   : divisor;
    assign coc_fin = neg_q ? -quo_paso : quo_paso;
    assign res_fin = neg_r ? -rem_paso : rem_paso;

    // Divide-by-zero keeps the all-ones quotient, so no negation then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (estado == REPOSO && inicio) begin
            neg_q <= con_signo && (dividendo[N-1] ^ divisor[N-1]) && (divisor != '0);
            neg_r <= con_signo && dividendo[N-1];
        end
    end
`else
    logic unused_con_signo;

    assign unused_con_signo = con_signo;
    assign dvd_mag = dividendo;
    assign dsr_mag = divisor;
    assign coc_fin = quo_paso;
    assign res_fin = rem_paso;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) estado <= REPOSO;
        else     estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO:  if (inicio) estado_sig = CALCULO;
            CALCULO: if (ultimo) estado_sig = FIN;
            FIN:     estado_sig = REPOSO;
            default: estado_sig = REPOSO;
        endcase
    end

    assign ocupado = (estado != REPOSO);
    assign valido  = (estado == FIN);

    // Results are registered on the last step so they are stable during FIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= '0;
            quo      <= '0;
            dsr      <= '0;
            cnt      <= '0;
            cociente <= '0;
            residuo  <= '0;
            div_cero <= 1'b0;
        end else begin
            case (estado)
                REPOSO: if (inicio) begin
                    rem <= '0;
                    quo <= dvd_mag;
                    dsr <= dsr_mag;
                    cnt <= CW'(N);
                end
                CALCULO: begin
                    rem <= rem_paso;
                    quo <= quo_paso;
                    cnt <= cnt - CW'(1);
                    if (ultimo) begin
                        cociente <= coc_fin;
                        residuo  <= res_fin;
                        div_cero <= (dsr == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
